// File: rtl/axi_status_poller_if.sv
// AXI4-Lite bus bundle between the status poller (master) and the status slave.
// No PROT channels; WSTRB is driven by the master.
interface axi_status_poller_if;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY,
        output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY,
        input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY
    );
endinterface

// File: rtl/axi_status_poller.sv
// AXI4-Lite master that polls a channel-up status register on a fixed period and
// also carries single-beat register writes from fabric over the same bus.
module axi_status_poller #(
    parameter logic [31:0] STATUS_ADDR    = 32'h0000_0000,
    parameter int unsigned POLL_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        axi_clk,
    input  logic        axi_reset,
    input  logic        poll_enable,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        cmd_ready,
    output logic        cmd_done,
    output logic [1:0]  cmd_bresp,
    output logic        ss0_up,
    output logic        ss1_up,
    output logic [31:0] status_word,
    output logic        status_changed,
    output logic [15:0] poll_error_count,
    output logic        timeout,
    axi_status_poller_if.master m_axi
);
    localparam int TMR_W = $clog2(POLL_CYCLES);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYCLES - 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              poll_pend_q, poll_pend_d;
    logic              aw_pend_q, aw_pend_d;
    logic              w_pend_q, w_pend_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       status_q, status_d;
    logic              changed_q, changed_d;
    logic [15:0]       err_q, err_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              done_q, done_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              poll_due;
    logic              poll_take;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        status_d  = status_q;
        changed_d = 1'b0;
        err_d     = err_q;
        bresp_d   = bresp_q;
        done_d    = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cmd_ready = 1'b0;
        poll_take = 1'b0;

        poll_due = poll_enable && (tmr_q == '0);
        if (!poll_enable || poll_due) begin
            tmr_d = TMR_RELOAD;
        end else begin
            tmr_d = tmr_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (poll_pend_q && poll_enable) begin
                    poll_take = 1'b1;
                    state_d   = RD_ADDR;
                end else if (cmd_write && !axi_reset) begin
                    cmd_ready = 1'b1;
                    state_d   = WR_REQ;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    waddr_d   = cmd_addr;
                    wdata_d   = cmd_wdata;
                end
            end
            RD_ADDR: begin
                if (m_axi.M_AXI_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi.M_AXI_RVALID) begin
                    state_d = IDLE;
                    if (m_axi.M_AXI_RRESP == 2'b00) begin
                        status_d  = m_axi.M_AXI_RDATA;
                        changed_d = (m_axi.M_AXI_RDATA != status_q);
                    end else begin
                        err_d = sat_inc16(err_q);
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave only once both have.
                if (m_axi.M_AXI_AWREADY) aw_pend_d = 1'b0;
                if (m_axi.M_AXI_WREADY)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi.M_AXI_BVALID) begin
                    bresp_d = m_axi.M_AXI_BRESP;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A timer expiry in the same cycle the previous poll is taken stays pending.
        poll_pend_d = poll_enable && (poll_due || (poll_pend_q && !poll_take));

        // The bus transaction is never abandoned; the watchdog only flags the stall.
        if (state_q == IDLE || state_d != state_q) begin
            wd_d = '0;
        end else if (wd_q == WD_LAST) begin
            timeout_d = 1'b1;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q     <= IDLE;
            tmr_q       <= TMR_RELOAD;
            poll_pend_q <= 1'b0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            status_q    <= '0;
            changed_q   <= 1'b0;
            err_q       <= '0;
            bresp_q     <= 2'b00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            poll_pend_q <= poll_pend_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            status_q    <= status_d;
            changed_q   <= changed_d;
            err_q       <= err_d;
            bresp_q     <= bresp_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge axi_clk) begin
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
    end

    assign m_axi.M_AXI_ARADDR  = STATUS_ADDR;
    assign m_axi.M_AXI_ARVALID = (state_q == RD_ADDR);
    assign m_axi.M_AXI_RREADY  = (state_q == RD_DATA);
    assign m_axi.M_AXI_AWADDR  = waddr_q;
    assign m_axi.M_AXI_AWVALID = (state_q == WR_REQ) && aw_pend_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = (state_q == WR_REQ) && w_pend_q;
    assign m_axi.M_AXI_BREADY  = (state_q == WR_RESP);

    assign cmd_done         = done_q;
    assign cmd_bresp        = bresp_q;
    assign status_word      = status_q;
    assign ss0_up           = status_q[0];
    assign ss1_up           = status_q[16];
    assign status_changed   = changed_q;
    assign poll_error_count = err_q;
    assign timeout          = timeout_q;
endmodule

// File: tb/tb_axi_status_poller.sv
// Directed/randomised bench for axi_status_poller: a reactive AXI4-Lite slave
// with a transaction-level model of the expected status, error and write results.
`timescale 1ns/1ps
module tb_axi_status_poller;
    localparam logic [31:0] SADDR = 32'h0000_0040;
    localparam int P  = 16;
    localparam int TO = 256;

    logic        axi_clk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        poll_enable = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, cmd_done, ss0_up, ss1_up, status_changed, timeout;
    logic [1:0]  cmd_bresp;
    logic [31:0] status_word;
    logic [15:0] poll_error_count;

    axi_status_poller_if bus();

    axi_status_poller #(.STATUS_ADDR(SADDR), .POLL_CYCLES(P), .TIMEOUT_CYCLES(TO)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .poll_enable(poll_enable),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_bresp(cmd_bresp),
        .ss0_up(ss0_up), .ss1_up(ss1_up), .status_word(status_word),
        .status_changed(status_changed), .poll_error_count(poll_error_count),
        .timeout(timeout), .m_axi(bus)
    );

    always #5 axi_clk = ~axi_clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    // slave behaviour knobs
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    bit          r_hold = 0;
    int          rd_mode = 0;
    logic [31:0] fix_data = 32'h0001_0001;
    logic [1:0]  fix_resp = 2'b00;
    logic [1:0]  b_resp = 2'b00;
    // slave observations
    int          n_ar, n_rd, n_aw, n_w, n_b, aw_cyc, addr_bad, aw_hi, w_hi, valid_drop;
    int          ar_cyc[$];
    logic [31:0] last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;
    // reference model: last OKAY data, change count, error count, write results
    logic [31:0] m_word;
    int          m_err, m_chg, m_done;
    logic [1:0]  m_bresp;
    // output monitors
    int          mon_chg, mon_done, mon_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge axi_clk); #1;
        axi_reset = 1'b1;
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk); #1;
        axi_reset = 1'b0;
    endtask

    task automatic wait_reads(input string tag, input int n);
        int target;
        target = n_rd + n;
        for (int i = 0; i < 20 * P * n && n_rd < target; i++) tick(1);
        check(tag, n_rd >= target, 1);
        tick(2);
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        cmd_addr = a; cmd_wdata = d; cmd_write = 1'b1;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin got = 1; break; end
            @(posedge axi_clk); #1;
        end
        if (got) begin @(posedge axi_clk); #1; end
        cmd_write = 1'b0;
        check("cmd_accepted", got, 1);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 100 && mon_done < n; i++) tick(1);
        check("cmd_done_seen", mon_done >= n, 1);
    endtask

    // Reactive slave: decides its outputs at each falling edge and records the
    // handshakes that the next rising edge will complete.
    initial begin : slave
        bit hs_ar, hs_r, hs_aw, hs_w, hs_b, aw_got, w_got, r_go;
        bit p_arv, p_awv, p_wv;
        int ar_cnt, aw_cnt, w_cnt;
        logic [31:0] d;
        logic [1:0]  rs;
        {hs_ar, hs_r, hs_aw, hs_w, hs_b, aw_got, w_got, r_go, p_arv, p_awv, p_wv} = '0;
        {ar_cnt, aw_cnt, w_cnt} = '0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = '0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = '0;
        forever begin
            @(negedge axi_clk);
            if (axi_reset) begin
                {hs_ar, hs_r, hs_aw, hs_w, hs_b, aw_got, w_got, r_go, p_arv, p_awv, p_wv} = '0;
                {ar_cnt, aw_cnt, w_cnt} = '0;
                bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_AWREADY = 0;
                bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
                {n_ar, n_rd, n_aw, n_w, n_b, aw_cyc, addr_bad, aw_hi, w_hi, valid_drop} = '0;
                ar_cyc.delete();
                m_word = '0; m_err = 0; m_chg = 0; m_done = 0; m_bresp = 2'b00;
            end else begin
                if (hs_r) bus.M_AXI_RVALID = 0;
                if (hs_b) bus.M_AXI_BVALID = 0;
                if (hs_ar) r_go = 1;
                if (hs_aw) aw_got = 1;
                if (hs_w)  w_got = 1;
                if (r_go && !r_hold) begin
                    if (rd_mode == 0) begin
                        d = fix_data; rs = fix_resp;
                    end else begin
                        case ($urandom_range(0, 4))
                            0: d = 32'h0000_0000;
                            1: d = 32'h0000_0001;
                            2: d = 32'h0001_0000;
                            3: d = 32'h0001_0001;
                            default: d = $urandom;
                        endcase
                        rs = ($urandom_range(0, 99) < 25) ? 2'b10 : 2'b00;
                    end
                    bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = d; bus.M_AXI_RRESP = rs;
                    r_go = 0;
                end
                if (aw_got && w_got) begin
                    bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = b_resp;
                    aw_got = 0; w_got = 0;
                end
                if ((p_arv && !hs_ar && !bus.M_AXI_ARVALID) || (p_awv && !hs_aw && !bus.M_AXI_AWVALID) ||
                    (p_wv && !hs_w && !bus.M_AXI_WVALID)) valid_drop++;
                if (bus.M_AXI_ARVALID) begin bus.M_AXI_ARREADY = (ar_cnt >= ar_delay); ar_cnt++; end
                else begin bus.M_AXI_ARREADY = 0; ar_cnt = 0; end
                if (bus.M_AXI_AWVALID) begin bus.M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; aw_hi++; end
                else begin bus.M_AXI_AWREADY = 0; aw_cnt = 0; end
                if (bus.M_AXI_WVALID) begin bus.M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++; w_hi++; end
                else begin bus.M_AXI_WREADY = 0; w_cnt = 0; end
                hs_ar = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
                hs_r  = bus.M_AXI_RVALID  && bus.M_AXI_RREADY;
                hs_aw = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
                hs_w  = bus.M_AXI_WVALID  && bus.M_AXI_WREADY;
                hs_b  = bus.M_AXI_BVALID  && bus.M_AXI_BREADY;
                if (hs_ar) begin
                    n_ar++; ar_cyc.push_back(cyc);
                    if (bus.M_AXI_ARADDR !== SADDR) addr_bad++;
                end
                if (hs_r) begin
                    n_rd++;
                    if (bus.M_AXI_RRESP == 2'b00) begin
                        if (bus.M_AXI_RDATA != m_word) m_chg++;
                        m_word = bus.M_AXI_RDATA;
                    end else if (m_err < 65535) begin
                        m_err++;
                    end
                end
                if (hs_aw) begin n_aw++; aw_cyc = cyc; last_awaddr = bus.M_AXI_AWADDR; end
                if (hs_w)  begin n_w++; last_wdata = bus.M_AXI_WDATA; last_wstrb = bus.M_AXI_WSTRB; end
                if (hs_b)  begin n_b++; m_done++; m_bresp = bus.M_AXI_BRESP; end
                p_arv = bus.M_AXI_ARVALID; p_awv = bus.M_AXI_AWVALID; p_wv = bus.M_AXI_WVALID;
            end
        end
    end

    initial begin : monitor
        mon_chg = 0; mon_done = 0; mon_ready = 0;
        forever begin
            @(negedge axi_clk);
            if (axi_reset) begin
                mon_chg = 0; mon_done = 0; mon_ready = 0;
            end else begin
                if (status_changed) mon_chg++;
                if (cmd_done) mon_done++;
                if (cmd_ready) mon_ready++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int bad, first_ar, x, aw0, w0;
        logic [31:0] a2, d2;
        bit seen;

        poll_enable = 1'b1;
        do_reset();
        check("reset_outputs",
              {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
               bus.M_AXI_BREADY, cmd_ready, cmd_done, cmd_bresp, ss0_up, ss1_up,
               status_changed, timeout, poll_error_count, status_word}, 64'd0);

        // first poll starts POLL_CYCLES+1 cycles after reset release
        repeat (P) @(posedge axi_clk);
        #1 check("arvalid_before_first_poll", bus.M_AXI_ARVALID, 0);
        @(posedge axi_clk);
        #1 check("arvalid_first_poll", bus.M_AXI_ARVALID, 1);

        tick(5 * P);
        check("polls_issued", ar_cyc.size() >= 5, 1);
        bad = 0;
        for (int i = 1; i < ar_cyc.size(); i++) if (ar_cyc[i] - ar_cyc[i-1] != P) bad++;
        check("poll_period", bad, 0);
        check("araddr", addr_bad, 0);
        check("status_word_up", status_word, 32'h0001_0001);
        check("ss_bits_up", {ss1_up, ss0_up}, 2'b11);
        check("changed_once", mon_chg, 1);

        // toggle SS1
        fix_data = 32'h0000_0001;
        wait_reads("reads_toggle_a", 2);
        check("ss_bits_ss1_down", {ss1_up, ss0_up}, 2'b01);
        check("status_word_ss1_down", status_word, 32'h0000_0001);
        check("changed_count_a", mon_chg, 2);
        fix_data = 32'h0001_0001;
        wait_reads("reads_toggle_b", 2);
        check("ss1_follows", ss1_up, 1);
        check("changed_count_b", mon_chg, 3);

        // three SLVERR polls
        fix_resp = 2'b10;
        wait_reads("reads_slverr", 3);
        fix_resp = 2'b00;
        check("err_count_3", poll_error_count, 3);
        check("status_kept_on_err", status_word, 32'h0001_0001);
        check("changed_unchanged_on_err", mon_chg, 3);

        // random data and responses against the model
        rd_mode = 1;
        wait_reads("reads_random", 24);
        rd_mode = 0;
        check("rand_status_word", status_word, m_word);
        check("rand_ss_bits", {ss1_up, ss0_up}, {m_word[16], m_word[0]});
        check("rand_err_count", poll_error_count, m_err);
        check("rand_changed_count", mon_chg, m_chg);

        // polling disabled
        poll_enable = 1'b0;
        tick(3);
        x = n_ar;
        tick(5 * P);
        check("no_poll_when_disabled", n_ar, x);
        poll_enable = 1'b1;

        // write collides with a due poll: read goes first
        aw_delay = 3; w_delay = 0; b_resp = 2'b00;
        do_reset();
        repeat (P) @(posedge axi_clk);
        #1;
        cmd_addr = 32'h0000_1234; cmd_wdata = 32'hCAFE_F00D; cmd_write = 1'b1;
        #1 check("poll_wins_no_ready", cmd_ready, 0);
        send_cmd(32'h0000_1234, 32'hCAFE_F00D);
        wait_done(1);
        first_ar = (ar_cyc.size() > 0) ? ar_cyc[0] : 32'h7FFF_FFFF;
        check("read_before_write", (n_aw == 1) && (first_ar < aw_cyc), 1);
        check("cmd_ready_pulses", mon_ready, 1);
        check("awvalid_cycles", aw_hi, 4);
        check("wvalid_cycles", w_hi, 1);
        check("awaddr", last_awaddr, 32'h0000_1234);
        check("wdata_wstrb", {last_wdata, last_wstrb}, {32'hCAFE_F00D, 4'hF});
        check("bresp_okay", cmd_bresp, m_bresp);
        check("cmd_done_count", mon_done, m_done);

        // second write with a delayed WREADY and SLVERR response
        aw_delay = 0; w_delay = 2; b_resp = 2'b10;
        a2 = $urandom; d2 = $urandom;
        aw0 = aw_hi; w0 = w_hi;
        tick(2);
        send_cmd(a2, d2);
        wait_done(2);
        check("bresp_slverr", cmd_bresp, 2'b10);
        check("awaddr2_wdata2", {last_awaddr, last_wdata}, {a2, d2});
        check("hi_cycles_2", {aw_hi - aw0, w_hi - w0}, {32'd1, 32'd3});
        check("valid_held", valid_drop, 0);

        // ARREADY stalled past the watchdog limit
        ar_delay = 300; b_resp = 2'b00;
        do_reset();
        for (int i = 0; i < P + 5 && !bus.M_AXI_ARVALID; i++) tick(1);
        check("stall_ar_started", bus.M_AXI_ARVALID, 1);
        tick(250);
        check("no_timeout_yet", {timeout, bus.M_AXI_ARVALID}, 2'b01);
        tick(40);
        check("timeout_set_arvalid_held", {timeout, bus.M_AXI_ARVALID}, 2'b11);
        wait_reads("stalled_read_completes", 1);
        ar_delay = 0;
        check("timeout_sticky", timeout, 1);
        check("status_after_stall", status_word, 32'h0001_0001);

        // reset while waiting in RD_DATA
        r_hold = 1;
        seen = 0;
        for (int i = 0; i < 3 * P && !seen; i++) begin tick(1); seen = bus.M_AXI_RREADY; end
        check("in_rd_data", seen, 1);
        axi_reset = 1'b1;
        @(posedge axi_clk);
        #1 check("reset_mid_read",
              {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
               bus.M_AXI_BREADY, cmd_ready, cmd_done, cmd_bresp, ss0_up, ss1_up,
               status_changed, timeout, poll_error_count, status_word}, 64'd0);
        r_hold = 0;
        @(negedge axi_clk); #1;
        axi_reset = 1'b0;
        wait_reads("read_after_reset", 1);
        check("status_after_reset", status_word, 32'h0001_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
